pipe_buf: RTL and testbench

PIPE_BUF -- requirements
Module: pipe_buf

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_buf_mem.sv | 40 ++++
 rtl/pipe_buf.sv | 99 +++++++++
 tb/tb_pipe_buf.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and helpers for the pipe_buf slice.
//   DEFAULT_WIDTH  - default payload width in bits
//   DEFAULT_DEPTH  - default entry count (power of two)
//   ptr_width()    - bits needed to index DEPTH entries
package pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;

  // Pointer width for a power-of-two depth; never less than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// pipe_buf_mem: DEPTH x WIDTH flop array, one write port, one asynchronous
// read port. Contents change only when we_i is high at a rising edge.
//   clk_i    - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data (combinational from the array)
module pipe_buf_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  // NOTE: the payload array has no reset; validity is tracked by the level
  // counter in the parent, so clearing data would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_buf.sv
// pipe_buf: valid/ready FIFO buffer with one-cycle latency and full
// throughput. Flags are decoded from the level register only, so there is no
// combinational path from either handshake input to data_rdy_o.
//   clk_i, rst_n_i  - clock, asynchronous active-low reset
//   flush_i         - synchronous discard of all entries (beats push/pop)
//   data_i/_vld_i   - upstream payload/valid; data_rdy_o - ready to upstream
//   data_o/_vld_o   - oldest entry/valid; data_rdy_i - ready from downstream
//   level_o         - number of stored entries
//   afull_o         - level_o >= AFULL
module pipe_buf
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AFULL = DEPTH - 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     data_vld_i,
  output logic                     data_rdy_o,
  output logic [WIDTH-1:0]         data_o,
  output logic                     data_vld_o,
  input  logic                     data_rdy_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     afull_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AFULL_LVL = LVL_W'(AFULL);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic             push, pop, mem_we;

  assign push = data_vld_i & data_rdy_o;
  assign pop  = data_vld_o & data_rdy_i;
  // A push accepted during a flush completes its handshake but is dropped.
  assign mem_we = push & ~flush_i;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Power-of-two depth: pointers wrap by plain overflow.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign data_rdy_o = (level_q != FULL_LVL);
  assign data_vld_o = (level_q != '0);
  assign afull_o    = (level_q >= AFULL_LVL);
  assign level_o    = level_q;

  pipe_buf_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_o)
  );

endmodule

// File: tb/tb_pipe_buf.sv
// tb_pipe_buf: self-checking bench for pipe_buf. Three instances (DEPTH 4, 2
// and 16) share all inputs; a reference model per instance keeps the log of
// accepted pushes plus push/pop counts, from which expected outputs follow.
module tb_pipe_buf;

  localparam int NI   = 3;
  localparam int LOGN = 16384;
  localparam int DEP [NI] = '{4, 2, 16};

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i;
  logic [31:0] data_i;
  logic        data_vld_i;
  logic        data_rdy_i;

  logic [31:0] dout   [NI];
  logic        vld_o  [NI];
  logic        rdy_o  [NI];
  logic        afull  [NI];
  logic [4:0]  lvl    [NI];
  logic [2:0]  lvl_4;
  logic [1:0]  lvl_2;
  logic [4:0]  lvl_16;

  assign lvl[0] = {2'b00, lvl_4};
  assign lvl[1] = {3'b000, lvl_2};
  assign lvl[2] = lvl_16;

  always #5 clk_i = ~clk_i;

  pipe_buf #(.WIDTH(32), .DEPTH(4)) u_dut4 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .data_i(data_i),
    .data_vld_i(data_vld_i), .data_rdy_o(rdy_o[0]), .data_o(dout[0]),
    .data_vld_o(vld_o[0]), .data_rdy_i(data_rdy_i), .level_o(lvl_4),
    .afull_o(afull[0]));

  pipe_buf #(.WIDTH(32), .DEPTH(2)) u_dut2 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .data_i(data_i),
    .data_vld_i(data_vld_i), .data_rdy_o(rdy_o[1]), .data_o(dout[1]),
    .data_vld_o(vld_o[1]), .data_rdy_i(data_rdy_i), .level_o(lvl_2),
    .afull_o(afull[1]));

  pipe_buf #(.WIDTH(32), .DEPTH(16)) u_dut16 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .data_i(data_i),
    .data_vld_i(data_vld_i), .data_rdy_o(rdy_o[2]), .data_o(dout[2]),
    .data_vld_o(vld_o[2]), .data_rdy_i(data_rdy_i), .level_o(lvl_16),
    .afull_o(afull[2]));

  // Reference model: everything ever accepted, in order, and two counters.
  logic [31:0] mlog  [NI][LOGN];
  int          wr_n  [NI];
  int          rd_n  [NI];
  bit          last_push0;

  int checks = 0;
  int errors = 0;

  function automatic int mlvl(input int k);
    return wr_n[k] - rd_n[k];
  endfunction

  function automatic logic [31:0] mhead(input int k);
    return mlog[k][rd_n[k] % LOGN];
  endfunction

  task automatic model_drop_all();
    for (int k = 0; k < NI; k++) rd_n[k] = wr_n[k];
  endtask

  // Advance one clock: decide transfers from the model, apply them at the
  // edge, return at the following falling edge.
  task automatic step();
    bit psh [NI];
    bit pp  [NI];
    for (int k = 0; k < NI; k++) begin
      psh[k] = data_vld_i && (mlvl(k) < DEP[k]);
      pp[k]  = data_rdy_i && (mlvl(k) > 0);
    end
    @(posedge clk_i);
    for (int k = 0; k < NI; k++) begin
      if (flush_i) begin
        rd_n[k] = wr_n[k];
      end else begin
        if (psh[k]) begin
          mlog[k][wr_n[k] % LOGN] = data_i;
          wr_n[k]++;
        end
        if (pp[k]) rd_n[k]++;
      end
    end
    last_push0 = psh[0];
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; flush_i = 1'b0; data_i = '0;
    data_vld_i = 1'b0; data_rdy_i = 1'b0;
    for (int k = 0; k < NI; k++) begin wr_n[k] = 0; rd_n[k] = 0; end
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({vld_o[k], rdy_o[k], afull[k], lvl[k]} !== {3'b010, 5'd0}) begin
        errors++;
        $display("FAIL reset[%0d]: vld/rdy/afull/level got %b%b%b/%0d, want 010/0",
                 k, vld_o[k], rdy_o[k], afull[k], lvl[k]);
      end
    end
    @(negedge clk_i); @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_fill();
    int pushes = 0;
    data_i = 32'hdeadbeef; data_vld_i = 1'b1; data_rdy_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int exp_lvl = (i < 4) ? i : 4;
      checks++;
      if (lvl[0] !== 5'(exp_lvl) || afull[0] !== (exp_lvl >= 3) ||
          rdy_o[0] !== (exp_lvl != 4)) begin
        errors++;
        $display("FAIL fill[%0d]: level/afull/rdy got %0d/%b/%b, want %0d/%b/%b",
                 i, lvl[0], afull[0], rdy_o[0], exp_lvl, exp_lvl >= 3, exp_lvl != 4);
      end
      step();
      if (last_push0) begin pushes++; data_i = data_i + 1; end
    end
    checks++;
    if (pushes != 4 || dout[0] !== 32'hdeadbeef || vld_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL fill_end: pushes/data/vld got %0d/%h/%b, want 4/deadbeef/1",
               pushes, dout[0], vld_o[0]);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    data_vld_i = 1'b1; data_rdy_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (vld_o[0] !== 1'b1 || dout[0] !== 32'hdeadbeef + 32'(i)) begin
        errors++;
        $display("FAIL stream[%0d]: vld/data got %b/%h, want 1/%h",
                 i, vld_o[0], dout[0], 32'hdeadbeef + 32'(i));
      end
      if (i > 0) begin
        checks++;
        if (lvl[0] !== 5'd3) begin
          errors++;
          $display("FAIL stream_level[%0d]: got %0d want 3", i, lvl[0]);
        end
      end
      step();
      if (last_push0) data_i = data_i + 1;
    end
    data_vld_i = 1'b0;
    while (mlvl(0) > 0 && n < 20) begin step(); n++; end
    checks++;
    if (lvl[0] !== 5'd0 || vld_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL drain: level/vld got %0d/%b, want 0/0", lvl[0], vld_o[0]);
    end
  endtask

  task automatic test_single();
    data_rdy_i = 1'b0; data_vld_i = 1'b1; data_i = 32'h12345678;
    step();
    data_vld_i = 1'b0;
    checks++;
    if (vld_o[0] !== 1'b1 || dout[0] !== 32'h12345678 || lvl[0] !== 5'd1) begin
      errors++;
      $display("FAIL single: vld/data/level got %b/%h/%0d, want 1/12345678/1",
               vld_o[0], dout[0], lvl[0]);
    end
    data_rdy_i = 1'b1;
    step();
    checks++;
    if (vld_o[0] !== 1'b0 || lvl[0] !== 5'd0) begin
      errors++;
      $display("FAIL single_pop: vld/level got %b/%0d, want 0/0", vld_o[0], lvl[0]);
    end
  endtask

  task automatic test_flush();
    data_rdy_i = 1'b0; data_vld_i = 1'b1;
    for (int i = 0; i < 3; i++) begin data_i = 32'ha0 + 32'(i); step(); end
    checks++;
    if (lvl[0] !== 5'd3 || afull[0] !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: level/afull got %0d/%b, want 3/1", lvl[0], afull[0]);
    end
    flush_i = 1'b1; data_i = 32'hcafef00d;
    checks++;
    if (rdy_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL flush_rdy: got %b want 1", rdy_o[0]);
    end
    step();
    flush_i = 1'b0; data_vld_i = 1'b0;
    checks++;
    if (lvl[0] !== 5'd0 || vld_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL flush: level/vld got %0d/%b, want 0/0", lvl[0], vld_o[0]);
    end
    data_rdy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (vld_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL flush_quiet[%0d]: vld got %b want 0", i, vld_o[0]);
      end
    end
    data_rdy_i = 1'b0; data_vld_i = 1'b1; data_i = 32'h0badc0de;
    step();
    data_vld_i = 1'b0;
    checks++;
    if (dout[0] !== 32'h0badc0de || lvl[0] !== 5'd1) begin
      errors++;
      $display("FAIL flush_after: data/level got %h/%0d, want 0badc0de/1",
               dout[0], lvl[0]);
    end
    data_rdy_i = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    data_rdy_i = 1'b0; data_vld_i = 1'b1;
    data_i = 32'h11110000; step();
    data_i = 32'h11110001; step();
    data_vld_i = 1'b0;
    checks++;
    if (lvl[0] !== 5'd2) begin
      errors++;
      $display("FAIL rst_mid_pre: level got %0d want 2", lvl[0]);
    end
    #2 rst_n_i = 1'b0;
    #1;
    model_drop_all();
    checks++;
    if ({vld_o[0], rdy_o[0], afull[0], lvl[0]} !== {3'b010, 5'd0}) begin
      errors++;
      $display("FAIL rst_mid: vld/rdy/afull/level got %b%b%b/%0d, want 010/0",
               vld_o[0], rdy_o[0], afull[0], lvl[0]);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    data_vld_i = 1'b1; data_i = 32'h5a5a5a5a;
    step();
    data_vld_i = 1'b0;
    checks++;
    if (dout[0] !== 32'h5a5a5a5a || lvl[0] !== 5'd1) begin
      errors++;
      $display("FAIL rst_mid_after: data/level got %h/%0d, want 5a5a5a5a/1",
               dout[0], lvl[0]);
    end
    data_rdy_i = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < NI; k++) begin
        int el = mlvl(k);
        checks++;
        if (lvl[k] !== 5'(el) || el > DEP[k]) begin
          errors++;
          $display("FAIL rnd_level[%0d] cyc %0d: got %0d want %0d", k, c, lvl[k], el);
        end
        checks++;
        if ({vld_o[k], rdy_o[k], afull[k]} !== {el != 0, el != DEP[k], el >= DEP[k] - 1}) begin
          errors++;
          $display("FAIL rnd_flags[%0d] cyc %0d: vld/rdy/afull got %b%b%b want %b%b%b",
                   k, c, vld_o[k], rdy_o[k], afull[k], el != 0, el != DEP[k], el >= DEP[k] - 1);
        end
        if (el > 0) begin
          checks++;
          if (dout[k] !== mhead(k)) begin
            errors++;
            $display("FAIL rnd_data[%0d] cyc %0d: got %h want %h", k, c, dout[k], mhead(k));
          end
        end
      end
      data_i     = $urandom;
      data_vld_i = (($urandom % 4) != 0);
      data_rdy_i = (($urandom % 3) != 0);
      flush_i    = (($urandom % 300) == 0);
      step();
    end
    flush_i = 1'b0; data_vld_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_single();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
